// File: rtl/ccu_pkg.sv
// Shared types and constants for the CCU snoop path: CR response layout,
// snoop FSM states and the cache-line offset used to align snoop addresses.
package ccu_pkg;

    // Matches the D-cache line width of the attached cores (64-byte lines).
    localparam int unsigned DcacheLineWidth = 512;
    localparam int unsigned LineOffset      = $clog2(DcacheLineWidth / 8);

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;
    localparam int unsigned CrWidth        = 5;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} snoop_state_e;

endpackage

// File: rtl/ccu_snoop_bcast.sv
// Broadcasts one snoop to all cached ports but the initiator, merges the CR
// responses and forwards CD data from a single port while draining the rest.
module ccu_snoop_bcast
    import ccu_pkg::*;
#(
    parameter int unsigned NoPorts      = 2,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned CdDataWidth  = 64,
    parameter int unsigned IdxW         = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AxiAddrWidth-1:0]        req_addr_i,
    input  logic [3:0]                     req_snoop_i,
    input  logic [IdxW-1:0]                req_initiator_i,
    output logic [NoPorts-1:0]             ac_valid_o,
    input  logic [NoPorts-1:0]             ac_ready_i,
    output logic [AxiAddrWidth-1:0]        ac_addr_o,
    output logic [3:0]                     ac_snoop_o,
    input  logic [NoPorts-1:0]             cr_valid_i,
    output logic [NoPorts-1:0]             cr_ready_o,
    input  logic [CrWidth*NoPorts-1:0]     cr_resp_i,
    input  logic [NoPorts-1:0]             cd_valid_i,
    output logic [NoPorts-1:0]             cd_ready_o,
    input  logic [CdDataWidth*NoPorts-1:0] cd_data_i,
    input  logic [NoPorts-1:0]             cd_last_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [CrWidth-1:0]             rsp_o,
    output logic                           data_valid_o,
    input  logic                           data_ready_i,
    output logic [CdDataWidth-1:0]         data_o,
    output logic                           data_last_o
);

    localparam logic [AxiAddrWidth-1:0] LineMask =
        ~((AxiAddrWidth'(1) << LineOffset) - AxiAddrWidth'(1));

    snoop_state_e            state_q, state_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [3:0]              snoop_q, snoop_d;
    logic [NoPorts-1:0]      ac_pend_q, ac_pend_d;
    logic [NoPorts-1:0]      cr_pend_q, cr_pend_d;
    // Ports still owing a CD line: the source plus every drained port.
    logic [NoPorts-1:0]      cd_pend_q, cd_pend_d;
    cr_resp_t                merge_q, merge_d;
    logic [IdxW-1:0]         src_q, src_d;
    logic                    src_set_q, src_set_d;

    logic [NoPorts-1:0]      targets;
    logic [NoPorts-1:0]      cr_hs;
    logic [NoPorts-1:0]      dt_vec;
    logic [CrWidth-1:0]      cr_or;
    logic [IdxW-1:0]         dt_first;

    assign ac_addr_o  = addr_q;
    assign ac_snoop_o = snoop_q;

    always_comb begin
        targets = '0;
        for (int p = 0; p < NoPorts; p++) begin
            targets[p] = (IdxW'(p) != req_initiator_i);
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        ac_pend_d = ac_pend_q;
        cr_pend_d = cr_pend_q;
        cd_pend_d = cd_pend_q;
        merge_d   = merge_q;
        src_d     = src_q;
        src_set_d = src_set_q;

        req_ready_o  = 1'b0;
        ac_valid_o   = '0;
        cr_ready_o   = '0;
        cd_ready_o   = '0;
        rsp_valid_o  = 1'b0;
        rsp_o        = merge_q;
        data_valid_o = 1'b0;
        data_o       = cd_data_i[src_q*CdDataWidth +: CdDataWidth];
        data_last_o  = 1'b0;

        cr_hs    = '0;
        dt_vec   = '0;
        cr_or    = '0;
        dt_first = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = ~rst_i;
                if (req_valid_i) begin
                    addr_d    = req_addr_i & LineMask;
                    snoop_d   = req_snoop_i;
                    ac_pend_d = targets;
                    cr_pend_d = targets;
                    cd_pend_d = '0;
                    merge_d   = '0;
                    src_d     = '0;
                    src_set_d = 1'b0;
                    state_d   = SNOOP;
                end
            end
            SNOOP: begin
                ac_valid_o = ac_pend_q;
                ac_pend_d  = ac_pend_q & ~ac_ready_i;
                // Registered ac_pend keeps CR closed in the cycle of its own AC handshake.
                cr_ready_o = cr_pend_q & ~ac_pend_q;
                cr_hs      = cr_ready_o & cr_valid_i;
                for (int p = 0; p < NoPorts; p++) begin
                    if (cr_hs[p]) begin
                        cr_or     = cr_or | cr_resp_i[CrWidth*p +: CrWidth];
                        dt_vec[p] = cr_resp_i[CrWidth*p + CrDataTransfer];
                    end
                end
                for (int p = NoPorts - 1; p >= 0; p--) begin
                    if (dt_vec[p]) begin
                        dt_first = IdxW'(p);
                    end
                end
                merge_d   = cr_resp_t'(merge_q | cr_or);
                cr_pend_d = cr_pend_q & ~cr_hs;
                cd_pend_d = cd_pend_q | dt_vec;
                if (!src_set_q && (dt_vec != '0)) begin
                    src_set_d = 1'b1;
                    src_d     = dt_first;
                end
                if (cr_pend_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = src_set_q ? DATA : IDLE;
                end
            end
            DATA: begin
                data_valid_o      = cd_valid_i[src_q] & cd_pend_q[src_q];
                data_last_o       = cd_last_i[src_q];
                cd_ready_o        = cd_pend_q;
                cd_ready_o[src_q] = data_ready_i & cd_pend_q[src_q];
                cd_pend_d         = cd_pend_q & ~(cd_valid_i & cd_ready_o & cd_last_i);
                if (cd_pend_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            cd_pend_q <= '0;
            merge_q   <= '0;
            src_q     <= '0;
            src_set_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            ac_pend_q <= ac_pend_d;
            cr_pend_q <= cr_pend_d;
            cd_pend_q <= cd_pend_d;
            merge_q   <= merge_d;
            src_q     <= src_d;
            src_set_q <= src_set_d;
        end
    end

endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// Directed bench for ccu_snoop_bcast: a 2-port and a 4-port instance driven
// cycle by cycle with hand-computed expectations.
module tb_ccu_snoop_bcast;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 2-port instance
    logic        d2_req_valid, d2_req_ready, d2_req_init;
    logic [63:0] d2_req_addr, d2_ac_addr, d2_data;
    logic [3:0]  d2_req_snoop, d2_ac_snoop;
    logic [1:0]  d2_ac_valid, d2_ac_ready, d2_cr_valid, d2_cr_ready;
    logic [1:0]  d2_cd_valid, d2_cd_ready, d2_cd_last;
    logic [9:0]  d2_cr_resp;
    logic [127:0] d2_cd_data;
    logic        d2_rsp_valid, d2_rsp_ready, d2_data_valid, d2_data_ready, d2_data_last;
    logic [4:0]  d2_rsp;

    // 4-port instance
    logic        d4_req_valid, d4_req_ready;
    logic [1:0]  d4_req_init;
    logic [63:0] d4_req_addr, d4_ac_addr, d4_data;
    logic [3:0]  d4_req_snoop, d4_ac_snoop;
    logic [3:0]  d4_ac_valid, d4_ac_ready, d4_cr_valid, d4_cr_ready;
    logic [3:0]  d4_cd_valid, d4_cd_ready, d4_cd_last;
    logic [19:0] d4_cr_resp;
    logic [255:0] d4_cd_data;
    logic        d4_rsp_valid, d4_rsp_ready, d4_data_valid, d4_data_ready, d4_data_last;
    logic [4:0]  d4_rsp;

    ccu_snoop_bcast #(.NoPorts(2), .AxiAddrWidth(64), .CdDataWidth(64)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(d2_req_valid), .req_ready_o(d2_req_ready), .req_addr_i(d2_req_addr),
        .req_snoop_i(d2_req_snoop), .req_initiator_i(d2_req_init),
        .ac_valid_o(d2_ac_valid), .ac_ready_i(d2_ac_ready), .ac_addr_o(d2_ac_addr),
        .ac_snoop_o(d2_ac_snoop),
        .cr_valid_i(d2_cr_valid), .cr_ready_o(d2_cr_ready), .cr_resp_i(d2_cr_resp),
        .cd_valid_i(d2_cd_valid), .cd_ready_o(d2_cd_ready), .cd_data_i(d2_cd_data),
        .cd_last_i(d2_cd_last),
        .rsp_valid_o(d2_rsp_valid), .rsp_ready_i(d2_rsp_ready), .rsp_o(d2_rsp),
        .data_valid_o(d2_data_valid), .data_ready_i(d2_data_ready), .data_o(d2_data),
        .data_last_o(d2_data_last)
    );

    ccu_snoop_bcast #(.NoPorts(4), .AxiAddrWidth(64), .CdDataWidth(64)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(d4_req_valid), .req_ready_o(d4_req_ready), .req_addr_i(d4_req_addr),
        .req_snoop_i(d4_req_snoop), .req_initiator_i(d4_req_init),
        .ac_valid_o(d4_ac_valid), .ac_ready_i(d4_ac_ready), .ac_addr_o(d4_ac_addr),
        .ac_snoop_o(d4_ac_snoop),
        .cr_valid_i(d4_cr_valid), .cr_ready_o(d4_cr_ready), .cr_resp_i(d4_cr_resp),
        .cd_valid_i(d4_cd_valid), .cd_ready_o(d4_cd_ready), .cd_data_i(d4_cd_data),
        .cd_last_i(d4_cd_last),
        .rsp_valid_o(d4_rsp_valid), .rsp_ready_i(d4_rsp_ready), .rsp_o(d4_rsp),
        .data_valid_o(d4_data_valid), .data_ready_i(d4_data_ready), .data_o(d4_data),
        .data_last_o(d4_data_last)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {d2_req_valid, d2_req_init, d2_req_addr, d2_req_snoop} = '0;
        {d2_ac_ready, d2_cr_valid, d2_cr_resp, d2_cd_valid, d2_cd_last, d2_cd_data} = '0;
        {d2_rsp_ready, d2_data_ready} = '0;
        {d4_req_valid, d4_req_init, d4_req_addr, d4_req_snoop} = '0;
        {d4_ac_ready, d4_cr_valid, d4_cr_resp, d4_cd_valid, d4_cd_last, d4_cd_data} = '0;
        {d4_rsp_ready, d4_data_ready} = '0;

        // Reset state
        #2;
        check_eq("rst_req_ready", 64'(d4_req_ready), 64'd0);
        check_eq("rst_ac_valid", 64'(d4_ac_valid), 64'd0);
        check_eq("rst_cr_ready", 64'(d4_cr_ready), 64'd0);
        check_eq("rst_cd_ready", 64'(d4_cd_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(d4_rsp_valid), 64'd0);
        check_eq("rst_data_valid", 64'(d4_data_valid), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("idle_req_ready4", 64'(d4_req_ready), 64'd1);

        // 2 ports, initiator 0, ReadShared, IsShared only, no data phase
        tick();
        d2_req_valid = 1'b1; d2_req_addr = 64'h8000_0014; d2_req_snoop = 4'h1; d2_req_init = 1'b0;
        #1 check_eq("t1_req_ready", 64'(d2_req_ready), 64'd1);
        tick();
        d2_req_valid = 1'b0;
        #1 check_eq("t1_ac_valid", 64'(d2_ac_valid), 64'h2);
        check_eq("t1_ac_addr", d2_ac_addr, 64'h8000_0000);
        check_eq("t1_ac_snoop", 64'(d2_ac_snoop), 64'h1);
        check_eq("t1_req_ready_busy", 64'(d2_req_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1 check_eq("t1_ac_hold", 64'(d2_ac_valid), 64'h2);
        end
        tick();
        d2_ac_ready = 2'b10;
        #1 check_eq("t1_ac_hs_valid", 64'(d2_ac_valid), 64'h2);
        check_eq("t1_cr_closed", 64'(d2_cr_ready), 64'h0);
        tick();
        d2_ac_ready = 2'b00; d2_cr_valid = 2'b10; d2_cr_resp = {5'b01000, 5'b00000};
        #1 check_eq("t1_cr_ready", 64'(d2_cr_ready), 64'h2);
        check_eq("t1_ac_done", 64'(d2_ac_valid), 64'h0);
        tick();
        d2_cr_valid = 2'b00; d2_rsp_ready = 1'b1;
        #1 check_eq("t1_rsp_valid", 64'(d2_rsp_valid), 64'd1);
        check_eq("t1_rsp", 64'(d2_rsp), 64'h08);
        tick();
        d2_rsp_ready = 1'b0;
        #1 check_eq("t1_back_idle", 64'(d2_req_ready), 64'd1);
        check_eq("t1_no_data", 64'(d2_data_valid), 64'd0);
        check_eq("t1_no_last", 64'(d2_data_last), 64'd0);
        check_eq("t1_data_idle", d2_data, 64'd0);
        check_eq("t1_cd_ready", 64'(d2_cd_ready), 64'd0);

        // 4 ports, initiator 2; ports 0 and 3 DataTransfer|PassDirty
        tick();
        d4_req_valid = 1'b1; d4_req_addr = 64'h1234_5678; d4_req_snoop = 4'h7; d4_req_init = 2'd2;
        #1 check_eq("t2_req_ready", 64'(d4_req_ready), 64'd1);
        tick();
        d4_req_valid = 1'b0; d4_ac_ready = 4'b1011; d4_cr_valid = 4'b0010; d4_cr_resp = '0;
        #1 check_eq("t2_ac_valid", 64'(d4_ac_valid), 64'hb);
        check_eq("t2_ac_addr", d4_ac_addr, 64'h1234_5640);
        check_eq("t2_ac_snoop", 64'(d4_ac_snoop), 64'h7);
        check_eq("t2_cr_same_cycle", 64'(d4_cr_ready), 64'h0);
        tick();
        d4_ac_ready = 4'b0000; d4_cr_valid = 4'b1011;
        d4_cr_resp = {5'b00101, 5'b00000, 5'b00000, 5'b00101};
        #1 check_eq("t2_cr_ready", 64'(d4_cr_ready), 64'hb);
        check_eq("t2_ac_done", 64'(d4_ac_valid), 64'h0);
        tick();
        d4_cr_valid = 4'b0000;
        #1 check_eq("t2_rsp_valid", 64'(d4_rsp_valid), 64'd1);
        check_eq("t2_rsp", 64'(d4_rsp), 64'h05);
        check_eq("t2_cr_closed", 64'(d4_cr_ready), 64'h0);
        tick();
        d4_rsp_ready = 1'b1;
        #1 check_eq("t2_rsp_hold", 64'(d4_rsp_valid), 64'd1);
        // data_ready low for 5 cycles; drain port 3 delivers 3 beats meanwhile
        for (int i = 0; i < 5; i++) begin
            tick();
            d4_rsp_ready = 1'b0; d4_data_ready = 1'b0;
            d4_cd_valid[0] = 1'b1; d4_cd_data[0 +: 64] = 64'hA0; d4_cd_last[0] = 1'b0;
            d4_cd_valid[3] = (i < 3); d4_cd_data[192 +: 64] = 64'hD0 + 64'(i);
            d4_cd_last[3] = (i == 2);
            #1 check_eq("t2_stall_valid", 64'(d4_data_valid), 64'd1);
            check_eq("t2_stall_data", d4_data, 64'hA0);
            check_eq("t2_stall_cd_ready", 64'(d4_cd_ready), (i < 3) ? 64'h8 : 64'h0);
            check_eq("t2_stall_busy", 64'(d4_req_ready), 64'd0);
        end
        tick();
        d4_data_ready = 1'b1; d4_cd_valid = 4'b0001; d4_cd_last = 4'b0000;
        #1 check_eq("t2_beat0_ready", 64'(d4_cd_ready), 64'h1);
        check_eq("t2_beat0_last", 64'(d4_data_last), 64'd0);
        check_eq("t2_rsp_gone", 64'(d4_rsp_valid), 64'd0);
        tick();
        d4_cd_data[0 +: 64] = 64'hA1; d4_cd_last[0] = 1'b1;
        #1 check_eq("t2_beat1_data", d4_data, 64'hA1);
        check_eq("t2_beat1_last", 64'(d4_data_last), 64'd1);
        check_eq("t2_not_idle_yet", 64'(d4_req_ready), 64'd0);
        tick();
        d4_cd_valid = '0; d4_cd_last = '0; d4_data_ready = 1'b0;
        #1 check_eq("t2_idle", 64'(d4_req_ready), 64'd1);
        check_eq("t2_idle_cd_ready", 64'(d4_cd_ready), 64'h0);
        check_eq("t2_idle_data_valid", 64'(d4_data_valid), 64'd0);

        // Initiator 0; port 2 DataTransfer|Error, line still forwarded
        tick();
        d4_req_valid = 1'b1; d4_req_addr = 64'h40; d4_req_snoop = 4'h0; d4_req_init = 2'd0;
        #1 check_eq("t3_req_ready", 64'(d4_req_ready), 64'd1);
        tick();
        d4_req_valid = 1'b0; d4_ac_ready = 4'b1110;
        #1 check_eq("t3_ac_valid", 64'(d4_ac_valid), 64'he);
        check_eq("t3_ac_addr", d4_ac_addr, 64'h40);
        tick();
        d4_ac_ready = 4'b0000; d4_cr_valid = 4'b1110;
        d4_cr_resp = {5'b00000, 5'b00011, 5'b00000, 5'b00000};
        #1 check_eq("t3_cr_ready", 64'(d4_cr_ready), 64'he);
        tick();
        d4_cr_valid = 4'b0000; d4_rsp_ready = 1'b1;
        #1 check_eq("t3_rsp", 64'(d4_rsp), 64'h03);
        for (int i = 0; i < 3; i++) begin
            tick();
            d4_rsp_ready = 1'b0; d4_data_ready = 1'b1;
            d4_cd_valid = 4'b0100; d4_cd_data[128 +: 64] = 64'h10 + 64'(i);
            d4_cd_last = (i == 2) ? 4'b0100 : 4'b0000;
            #1 check_eq("t3_data_valid", 64'(d4_data_valid), 64'd1);
            check_eq("t3_data", d4_data, 64'h10 + 64'(i));
            check_eq("t3_last", 64'(d4_data_last), (i == 2) ? 64'd1 : 64'd0);
            check_eq("t3_cd_ready", 64'(d4_cd_ready), 64'h4);
        end
        tick();
        d4_cd_valid = '0; d4_cd_last = '0; d4_data_ready = 1'b0;
        #1 check_eq("t3_idle", 64'(d4_req_ready), 64'd1);

        // Initiator 1; port 3 sources data; async reset after 2 beats
        tick();
        d4_req_valid = 1'b1; d4_req_addr = 64'h100; d4_req_init = 2'd1;
        #1 check_eq("t4_req_ready", 64'(d4_req_ready), 64'd1);
        tick();
        d4_req_valid = 1'b0; d4_ac_ready = 4'b1101;
        #1 check_eq("t4_ac_valid", 64'(d4_ac_valid), 64'hd);
        tick();
        d4_ac_ready = 4'b0000; d4_cr_valid = 4'b1101; d4_cr_resp = {5'b00001, 15'd0};
        #1 check_eq("t4_cr_ready", 64'(d4_cr_ready), 64'hd);
        tick();
        d4_cr_valid = 4'b0000; d4_rsp_ready = 1'b1;
        #1 check_eq("t4_rsp", 64'(d4_rsp), 64'h01);
        for (int i = 0; i < 2; i++) begin
            tick();
            d4_rsp_ready = 1'b0; d4_data_ready = 1'b1;
            d4_cd_valid = 4'b1000; d4_cd_data[192 +: 64] = 64'h30 + 64'(i);
            #1 check_eq("t4_data", d4_data, 64'h30 + 64'(i));
            check_eq("t4_cd_ready", 64'(d4_cd_ready), 64'h8);
        end
        tick();
        d4_cd_data[192 +: 64] = 64'h32;
        rst = 1'b1;
        #1 check_eq("t4_rst_data_valid", 64'(d4_data_valid), 64'd0);
        check_eq("t4_rst_cd_ready", 64'(d4_cd_ready), 64'h0);
        check_eq("t4_rst_ac_valid", 64'(d4_ac_valid), 64'h0);
        check_eq("t4_rst_cr_ready", 64'(d4_cr_ready), 64'h0);
        check_eq("t4_rst_rsp_valid", 64'(d4_rsp_valid), 64'd0);
        check_eq("t4_rst_req_ready", 64'(d4_req_ready), 64'd0);
        tick();
        rst = 1'b0; d4_cd_valid = '0; d4_data_ready = 1'b0;
        #1 check_eq("t4_post_req_ready", 64'(d4_req_ready), 64'd1);
        check_eq("t4_post_rsp_valid", 64'(d4_rsp_valid), 64'd0);
        tick();
        #1 check_eq("t4_post_rsp_valid2", 64'(d4_rsp_valid), 64'd0);
        check_eq("t4_post_data_valid", 64'(d4_data_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
